// File: rtl/tetris_grid_commit_ctrl.sv
// rtl/tetris_grid_commit_ctrl.sv - playfield grid shadow arbitration, windowed commit and gravity tick
module tetris_grid_commit_ctrl #(
  parameter int GRID_BITS = 200,
  parameter int V_TOTAL   = 525,
  parameter int WIN_START = 428
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_tick,
  input  logic                 frame_sync,
  input  logic                 req_a,
  input  logic [GRID_BITS-1:0] data_a,
  output logic                 ack_a,
  input  logic                 req_b,
  input  logic [GRID_BITS-1:0] data_b,
  output logic                 ack_b,
  input  logic [5:0]           drop_div,
  output logic [GRID_BITS-1:0] grid_a,
  output logic [GRID_BITS-1:0] grid_b,
  output logic                 committed,
  output logic                 drop_tick
);

  localparam int LW = $clog2(V_TOTAL);

  typedef enum logic [1:0] {WAIT_WIN, COMMIT, HOLD} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        line_q, line_d;
  logic [GRID_BITS-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic                 val_a_q, val_a_d, val_b_q, val_b_d;
  logic [GRID_BITS-1:0] grid_a_q, grid_a_d, grid_b_q, grid_b_d;
  logic                 gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                 rr_q, rr_d;
  logic                 committed_q, committed_d;
  logic [5:0]           frame_q, frame_d;
  logic                 drop_q, drop_d;

  logic                 line_wrap, to_zero, in_win, elig_a, elig_b;
  logic [6:0]           frame_inc;
  logic [5:0]           div_eff;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    grid_a_d    = grid_a_q;
    grid_b_d    = grid_b_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    rr_d        = rr_q;
    committed_d = 1'b0;
    frame_d     = frame_q;
    drop_d      = 1'b0;

    line_wrap = line_tick && (line_q == LW'(V_TOTAL - 1));
    to_zero   = frame_sync || line_wrap;
    in_win    = (line_q >= LW'(WIN_START));

    if (frame_sync) begin
      line_d = '0;
    end else if (line_tick) begin
      line_d = line_wrap ? '0 : line_q + 1'b1;
    end

    // A pending grant also blocks eligibility: the shadow only turns valid at the end of the ack cycle.
    elig_a = req_a && !val_a_q && !gnt_a_q && (state_q != COMMIT);
    elig_b = req_b && !val_b_q && !gnt_b_q && (state_q != COMMIT);

    if (elig_a && elig_b) begin
      gnt_a_d = !rr_q;
      gnt_b_d = rr_q;
      rr_d    = !rr_q;
    end else if (elig_a) begin
      gnt_a_d = 1'b1;
    end else if (elig_b) begin
      gnt_b_d = 1'b1;
    end

    case (state_q)
      WAIT_WIN: begin
        if (in_win && (val_a_q || val_b_q)) state_d = COMMIT;
      end
      COMMIT: begin
        if (val_a_q) begin
          grid_a_d = sh_a_q;
          val_a_d  = 1'b0;
        end
        if (val_b_q) begin
          grid_b_d = sh_b_q;
          val_b_d  = 1'b0;
        end
        committed_d = 1'b1;
        state_d     = to_zero ? WAIT_WIN : HOLD;
      end
      HOLD: begin
        if (to_zero) state_d = WAIT_WIN;
      end
      default: state_d = WAIT_WIN;
    endcase

    if (gnt_a_q) begin
      sh_a_d  = data_a;
      val_a_d = 1'b1;
    end
    if (gnt_b_q) begin
      sh_b_d  = data_b;
      val_b_d = 1'b1;
    end

    div_eff   = (drop_div == 6'd0) ? 6'd1 : drop_div;
    frame_inc = {1'b0, frame_q} + 7'd1;
    if (frame_sync) begin
      if (frame_inc >= {1'b0, div_eff}) begin
        frame_d = '0;
        drop_d  = 1'b1;
      end else begin
        frame_d = frame_inc[5:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_WIN;
      line_q      <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      val_a_q     <= 1'b0;
      val_b_q     <= 1'b0;
      grid_a_q    <= '0;
      grid_b_q    <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rr_q        <= 1'b0;
      committed_q <= 1'b0;
      frame_q     <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      grid_a_q    <= grid_a_d;
      grid_b_q    <= grid_b_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      rr_q        <= rr_d;
      committed_q <= committed_d;
      frame_q     <= frame_d;
      drop_q      <= drop_d;
    end
  end

  assign ack_a     = gnt_a_q;
  assign ack_b     = gnt_b_q;
  assign grid_a    = grid_a_q;
  assign grid_b    = grid_b_q;
  assign committed = committed_q;
  assign drop_tick = drop_q;

endmodule

// File: tb/tb_tetris_grid_commit_ctrl.sv
// tb/tb_tetris_grid_commit_ctrl.sv - directed vector bench for tetris_grid_commit_ctrl
module tb_tetris_grid_commit_ctrl;

  localparam int GB = 200;
  localparam int VT = 525;

  logic          clk = 1'b0;
  logic          rst, line_tick, frame_sync, req_a, req_b;
  logic [GB-1:0] data_a, data_b;
  logic [5:0]    drop_div;
  logic          ack_a, ack_b, committed, drop_tick;
  logic [GB-1:0] grid_a, grid_b;

  tetris_grid_commit_ctrl dut (
    .clk(clk), .rst(rst), .line_tick(line_tick), .frame_sync(frame_sync),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .drop_div(drop_div), .grid_a(grid_a), .grid_b(grid_b),
    .committed(committed), .drop_tick(drop_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, lt, fs, ra;
    logic [7:0] da;
    logic       rb;
    logic [7:0] db;
    logic [5:0] div;
    logic       e_aa, e_ab, e_cm, e_dt;
    logic [7:0] e_ga, e_gb;
  } vec_t;

  vec_t          tbl[15];
  int            n_pass = 0;
  int            n_total = 0;
  int            line_m = 0;
  int            c_ack_a, c_ack_b, c_commit, c_drop;
  logic [GB-1:0] cg_a, cg_b;
  logic [8:0]    mask;

  function automatic vec_t mk(input logic r, input logic lt, input logic fs, input logic ra,
                              input logic [7:0] da, input logic rb, input logic [7:0] db,
                              input logic [5:0] dv, input logic eaa, input logic eab,
                              input logic ecm, input logic edt, input logic [7:0] ega,
                              input logic [7:0] egb);
    vec_t v;
    v.rst = r; v.lt = lt; v.fs = fs; v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.div = dv;
    v.e_aa = eaa; v.e_ab = eab; v.e_cm = ecm; v.e_dt = edt; v.e_ga = ega; v.e_gb = egb;
    return v;
  endfunction

  task automatic check(input string name, input logic [GB-1:0] act, input logic [GB-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst || frame_sync) line_m = 0;
    else if (line_tick) line_m = (line_m + 1) % VT;
    c_ack_a += int'(ack_a);
    c_ack_b += int'(ack_b);
    c_drop  += int'(drop_tick);
    if (committed) begin
      c_commit++;
      cg_a = grid_a;
      cg_b = grid_b;
    end
  endtask

  task automatic clr();
    c_ack_a = 0; c_ack_b = 0; c_commit = 0; c_drop = 0; cg_a = '0; cg_b = '0;
  endtask

  task automatic adv(input int n);
    line_tick = 1'b1;
    repeat (n) tick();
    line_tick = 1'b0;
  endtask

  task automatic goto_line(input int t);
    adv((t - line_m + VT) % VT);
  endtask

  initial begin
    rst = 1'b1; line_tick = 1'b0; frame_sync = 1'b0; req_a = 1'b0; req_b = 1'b0;
    data_a = '0; data_b = '0; drop_div = 6'd1;
    clr();

    // reset with req_a held, contended grant, drop tick with div 0/2 and a mid-count div change
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b1,8'h05,1'b0,8'h00,6'd1, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[1]  = mk(1'b1,1'b0,1'b0,1'b1,8'h05,1'b0,8'h00,6'd1, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[2]  = mk(1'b1,1'b0,1'b0,1'b1,8'h05,1'b0,8'h00,6'd1, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[3]  = mk(1'b0,1'b0,1'b0,1'b1,8'h05,1'b1,8'h3C,6'd1, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[4]  = mk(1'b0,1'b0,1'b0,1'b1,8'h05,1'b1,8'h3C,6'd1, 1'b0,1'b1,1'b0,1'b0,8'h00,8'h00);
    tbl[5]  = mk(1'b0,1'b0,1'b0,1'b0,8'h05,1'b1,8'h3C,6'd1, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[6]  = mk(1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,6'd1, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[7]  = mk(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,6'd0, 1'b0,1'b0,1'b0,1'b1,8'h00,8'h00);
    tbl[8]  = mk(1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,6'd2, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[9]  = mk(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,6'd2, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[10] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,6'd2, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[11] = mk(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,6'd2, 1'b0,1'b0,1'b0,1'b1,8'h00,8'h00);
    tbl[12] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,6'd2, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[13] = mk(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,6'd2, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00);
    tbl[14] = mk(1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,6'd1, 1'b0,1'b0,1'b0,1'b1,8'h00,8'h00);

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; line_tick = tbl[i].lt; frame_sync = tbl[i].fs;
      req_a = tbl[i].ra; data_a = GB'(tbl[i].da);
      req_b = tbl[i].rb; data_b = GB'(tbl[i].db);
      drop_div = tbl[i].div;
      tick();
      check($sformatf("v%0d ack_a", i), GB'(ack_a), GB'(tbl[i].e_aa));
      check($sformatf("v%0d ack_b", i), GB'(ack_b), GB'(tbl[i].e_ab));
      check($sformatf("v%0d committed", i), GB'(committed), GB'(tbl[i].e_cm));
      check($sformatf("v%0d drop_tick", i), GB'(drop_tick), GB'(tbl[i].e_dt));
      check($sformatf("v%0d grid_a", i), grid_a, GB'(tbl[i].e_ga));
      check($sformatf("v%0d grid_b", i), grid_b, GB'(tbl[i].e_gb));
    end
    rst = 1'b0; frame_sync = 1'b0; req_a = 1'b0; req_b = 1'b0; drop_div = 6'd1;

    // outputs hold until the window, commit lands two cycles after line 428
    clr();
    goto_line(427);
    check("pre_win commits", GB'(c_commit), GB'(0));
    check("pre_win grid_a", grid_a, GB'(0));
    adv(1);
    check("line428 committed", GB'(committed), GB'(0));
    tick();
    tick();
    check("win committed", GB'(committed), GB'(1));
    check("win grid_a", grid_a, GB'(8'h05));
    check("win grid_b", grid_b, GB'(8'h3C));
    tick();
    check("committed pulse end", GB'(committed), GB'(0));

    // round robin pointer now favours B; then a second A update waits for the commit
    req_a = 1'b1; data_a = GB'(8'h01); req_b = 1'b1; data_b = GB'(8'h77);
    tick();
    check("rr2 ack_b", GB'(ack_b), GB'(1));
    check("rr2 ack_a", GB'(ack_a), GB'(0));
    tick();
    check("rr2b ack_a", GB'(ack_a), GB'(1));
    check("rr2b ack_b", GB'(ack_b), GB'(0));
    req_b = 1'b0;
    tick();
    check("no regrant in ack cycle", GB'(ack_a), GB'(0));
    data_a = GB'(8'h02);
    clr();
    goto_line(0);
    goto_line(428);
    tick();
    tick();
    check("frameN ack_a withheld", GB'(c_ack_a), GB'(0));
    check("frameN commits", GB'(c_commit), GB'(1));
    check("frameN grid_a", cg_a, GB'(8'h01));
    check("frameN grid_b", cg_b, GB'(8'h77));
    clr();
    repeat (3) tick();
    check("post commit ack_a", GB'(c_ack_a), GB'(1));
    req_a = 1'b0;
    clr();
    goto_line(0);
    goto_line(428);
    tick();
    tick();
    check("frameN1 commits", GB'(c_commit), GB'(1));
    check("frameN1 grid_a", cg_a, GB'(8'h02));
    check("frameN1 grid_b kept", grid_b, GB'(8'h77));

    // reset landing on the COMMIT cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = 1'b1; data_a = GB'(12'hABC);
    tick();
    tick();
    req_a = 1'b0;
    goto_line(428);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst commit committed", GB'(committed), GB'(0));
    check("rst commit grid_a", grid_a, GB'(0));
    check("rst commit grid_b", grid_b, GB'(0));
    clr();
    goto_line(428);
    repeat (3) tick();
    goto_line(0);
    check("rst shadows invalid", GB'(c_commit), GB'(0));
    req_b = 1'b1; data_b = GB'(8'h55);
    tick();
    tick();
    req_b = 1'b0;
    clr();
    goto_line(428);
    tick();
    tick();
    check("post rst commit", GB'(c_commit), GB'(1));
    check("post rst grid_b", cg_b, GB'(8'h55));
    check("post rst grid_a", grid_a, GB'(0));

    // gravity tick every third frame, then every frame with div 0
    drop_div = 6'd3;
    clr();
    mask = '0;
    for (int i = 0; i < 9; i++) begin
      frame_sync = 1'b1;
      tick();
      mask[i] = drop_tick;
      frame_sync = 1'b0;
      tick();
      tick();
    end
    check("div3 pulses", GB'(c_drop), GB'(3));
    check("div3 frames", GB'(mask), GB'(9'h124));
    drop_div = 6'd0;
    clr();
    repeat (4) begin
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      tick();
    end
    check("div0 pulses", GB'(c_drop), GB'(4));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
